// File: rtl/benes_cfg_if.sv
// benes_cfg_if: configuration write port, run control and switch-select outputs of the
// Benes configuration sequencer. Extra loop/abort controls exist when BENES_CFG_LOOP_EN is defined.
interface benes_cfg_if #(
  parameter int unsigned STAGE_NUM  = 9,
  parameter int unsigned SWITCH_NUM = 16,
  parameter int unsigned CFG_DEPTH  = 16
);
  localparam int unsigned AW = $clog2(CFG_DEPTH);
  localparam int unsigned SW = $clog2(STAGE_NUM);

  logic                  i_cfg_wen;
  logic [AW-1:0]         i_cfg_addr;
  logic [SW-1:0]         i_cfg_stage;
  logic                  i_cfg_net;
  logic [SWITCH_NUM-1:0] i_cfg_wdata;
  logic                  i_start;
  logic [AW-1:0]         i_base;
  logic [AW:0]           i_len;
  logic                  i_stall;
`ifdef BENES_CFG_LOOP_EN
  logic                  i_loop;
  logic                  i_abort;
`endif
  logic [SWITCH_NUM-1:0] o_module_select [0:STAGE_NUM-1];
  logic [SWITCH_NUM-1:0] o_slot_select   [0:STAGE_NUM-1];
  logic                  o_valid;
  logic                  o_last;
  logic [AW-1:0]         o_idx;
  logic                  o_busy;

  modport master (
`ifdef BENES_CFG_LOOP_EN
    output i_loop, output i_abort,
`endif
    output i_cfg_wen, output i_cfg_addr, output i_cfg_stage, output i_cfg_net,
    output i_cfg_wdata, output i_start, output i_base, output i_len, output i_stall,
    input  o_module_select, input o_slot_select, input o_valid, input o_last,
    input  o_idx, input o_busy
  );

  modport slave (
`ifdef BENES_CFG_LOOP_EN
    input  i_loop, input i_abort,
`endif
    input  i_cfg_wen, input i_cfg_addr, input i_cfg_stage, input i_cfg_net,
    input  i_cfg_wdata, input i_start, input i_base, input i_len, input i_stall,
    output o_module_select, output o_slot_select, output o_valid, output o_last,
    output o_idx, output o_busy
  );
endinterface

// File: rtl/benes_cfg_sequencer.sv
// benes_cfg_sequencer: stores precomputed Benes switch configurations (R2M + M2R sets per
// entry) and plays a contiguous, wrapping run of entries onto the interconnect selects.
// Optional macro BENES_CFG_LOOP_EN adds looping runs (i_loop) and run abort (i_abort).
module benes_cfg_sequencer #(
  parameter int unsigned STAGE_NUM  = 9,
  parameter int unsigned SWITCH_NUM = 16,
  parameter int unsigned CFG_DEPTH  = 16
) (
  input logic        clk,
  input logic        rst_n,
  benes_cfg_if.slave bus
);
  localparam int unsigned AW = $clog2(CFG_DEPTH);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [SWITCH_NUM-1:0] mem    [CFG_DEPTH][2][STAGE_NUM];
  logic [SWITCH_NUM-1:0] mod_q  [STAGE_NUM];
  logic [SWITCH_NUM-1:0] slot_q [STAGE_NUM];
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d, idx_q, idx_d, base_q, base_d;
  logic [AW:0]           rem_q, rem_d, len_q, len_d;
  logic                  valid_q, valid_d, last_q, last_d, busy_q;
  logic                  load, start_ok, consume, finish, wrap, abort;

  assign start_ok = bus.i_start && (bus.i_len != '0);
  assign consume  = valid_q && last_q && !bus.i_stall;
  assign finish   = abort || (consume && !wrap);

`ifdef BENES_CFG_LOOP_EN
  logic loop_q;
  assign abort = bus.i_abort;
  assign wrap  = loop_q;

  // Loop mode is captured once per run at the start command.
  always_ff @(posedge clk) begin
    if (!rst_n)                          loop_q <= 1'b0;
    else if (state_q == IDLE && start_ok) loop_q <= bus.i_loop;
  end
`else
  assign abort = 1'b0;
  assign wrap  = 1'b0;
`endif

  // Configuration storage; writes are accepted in any state, out-of-range stage rows dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem <= '{default: '0};
    end else if (bus.i_cfg_wen && (32'(bus.i_cfg_stage) < STAGE_NUM)) begin
      mem[bus.i_cfg_addr][bus.i_cfg_net][bus.i_cfg_stage] <= bus.i_cfg_wdata;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = RUN;
      RUN:     if (finish)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values; the final load of a looping run reloads the run pointers.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    rem_d    = rem_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    last_d   = last_q;
    base_d   = base_q;
    len_d    = len_q;
    load     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          rd_ptr_d = bus.i_base;
          rem_d    = bus.i_len;
          base_d   = bus.i_base;
          len_d    = bus.i_len;
        end
      end
      RUN: begin
        if (finish) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
        end else if (!valid_q || !bus.i_stall) begin
          load    = 1'b1;
          idx_d   = rd_ptr_q;
          valid_d = 1'b1;
          last_d  = (rem_q == (AW+1)'(1));
          if (last_d && wrap) begin
            rd_ptr_d = base_q;
            rem_d    = len_q;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            rem_d    = rem_q - 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Output and pointer registers; selects keep the last entry after a run ends.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      rem_q    <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      base_q   <= '0;
      len_q    <= '0;
      busy_q   <= 1'b0;
      mod_q    <= '{default: '0};
      slot_q   <= '{default: '0};
    end else begin
      rd_ptr_q <= rd_ptr_d;
      rem_q    <= rem_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      base_q   <= base_d;
      len_q    <= len_d;
      busy_q   <= (state_d == RUN);
      if (load) begin
        mod_q  <= mem[rd_ptr_q][0];
        slot_q <= mem[rd_ptr_q][1];
      end
    end
  end

  assign bus.o_module_select = mod_q;
  assign bus.o_slot_select   = slot_q;
  assign bus.o_valid         = valid_q;
  assign bus.o_last          = last_q;
  assign bus.o_idx           = idx_q;
  assign bus.o_busy          = busy_q;
endmodule

// File: tb/tb_benes_cfg_sequencer.sv
// tb_benes_cfg_sequencer: scoreboard bench for benes_cfg_sequencer with a behavioural
// storage model; covers the loop/abort controls when BENES_CFG_LOOP_EN is defined.
module tb_benes_cfg_sequencer;
  localparam int STAGE_NUM  = 9;
  localparam int SWITCH_NUM = 16;
  localparam int CFG_DEPTH  = 16;
  localparam int AW         = 4;
  localparam int SW         = 4;
  localparam int FW         = STAGE_NUM * SWITCH_NUM;

  typedef struct {
    logic [AW-1:0] idx;
    logic          last;
    logic [FW-1:0] mods;
    logic [FW-1:0] slots;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  bit   chk_en   = 1'b1;

  logic [SWITCH_NUM-1:0] m [CFG_DEPTH][2][STAGE_NUM];
  exp_t q[$];
  exp_t last_exp;
  logic [FW-1:0] dut_mod, dut_slot;

  benes_cfg_if #(.STAGE_NUM(STAGE_NUM), .SWITCH_NUM(SWITCH_NUM), .CFG_DEPTH(CFG_DEPTH)) bus ();

  benes_cfg_sequencer #(.STAGE_NUM(STAGE_NUM), .SWITCH_NUM(SWITCH_NUM), .CFG_DEPTH(CFG_DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    dut_mod  = '0;
    dut_slot = '0;
    for (int s = 0; s < STAGE_NUM; s++) begin
      dut_mod[s*SWITCH_NUM +: SWITCH_NUM]  = bus.o_module_select[s];
      dut_slot[s*SWITCH_NUM +: SWITCH_NUM] = bus.o_slot_select[s];
    end
  end

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [FW-1:0] flat(input int e, input int n);
    logic [FW-1:0] r;
    r = '0;
    for (int s = 0; s < STAGE_NUM; s++) r[s*SWITCH_NUM +: SWITCH_NUM] = m[e][n][s];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int e = 0; e < CFG_DEPTH; e++)
      for (int n = 0; n < 2; n++)
        for (int s = 0; s < STAGE_NUM; s++) m[e][n][s] = '0;
  endtask

  task automatic cfg_write(input int a, input int n, input int s, input logic [SWITCH_NUM-1:0] d);
    bus.i_cfg_addr  = AW'(a);
    bus.i_cfg_net   = 1'(n);
    bus.i_cfg_stage = SW'(s);
    bus.i_cfg_wdata = d;
    bus.i_cfg_wen   = 1'b1;
    tick();
    bus.i_cfg_wen   = 1'b0;
    if (s < STAGE_NUM) m[a][n][s] = d;
  endtask

  // Expected run: len entries from base, wrapping modulo the depth, with current contents.
  task automatic push_run(input int base, input int len);
    exp_t r;
    for (int k = 0; k < len; k++) begin
      int e = (base + k) % CFG_DEPTH;
      r.idx   = AW'(e);
      r.last  = (k == len - 1);
      r.mods  = flat(e, 0);
      r.slots = flat(e, 1);
      q.push_back(r);
      last_exp = r;
    end
  endtask

  task automatic start_run(input int base, input int len, input bit expect_run);
    if (expect_run) push_run(base, len);
    bus.i_base  = AW'(base);
    bus.i_len   = (AW+1)'(len);
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
  endtask

  task automatic wait_idle(input bit rnd);
    int n = 0;
    while (bus.o_busy && n < 300) begin
      bus.i_stall = rnd ? ($urandom_range(0, 2) == 0) : 1'b0;
      tick();
      n++;
    end
    bus.i_stall = 1'b0;
    if (bus.o_busy) chk("run_timeout", FW'(1), FW'(0));
    chk("sb_drained", FW'(q.size()), FW'(0));
  endtask

  // Scoreboard monitor: every presented entry is checked; it is retired when consumed.
  always @(negedge clk) begin
    if (chk_en && rst_n && bus.o_valid) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_valid actual idx=%0d required=no output", bus.o_idx);
      end else begin
        chk("sb_idx",   FW'(bus.o_idx),  FW'(q[0].idx));
        chk("sb_last",  FW'(bus.o_last), FW'(q[0].last));
        chk("sb_mod",   dut_mod,         q[0].mods);
        chk("sb_slot",  dut_slot,        q[0].slots);
        if (!bus.i_stall) void'(q.pop_front());
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    bus.i_cfg_wen = 1'b0; bus.i_cfg_addr = '0; bus.i_cfg_stage = '0; bus.i_cfg_net = 1'b0;
    bus.i_cfg_wdata = '0; bus.i_start = 1'b0; bus.i_base = '0; bus.i_len = '0; bus.i_stall = 1'b0;
`ifdef BENES_CFG_LOOP_EN
    bus.i_loop = 1'b0; bus.i_abort = 1'b0;
`endif
    model_clear();
    tick(); tick();
    chk("rst_valid", FW'(bus.o_valid), FW'(0));
    chk("rst_last",  FW'(bus.o_last),  FW'(0));
    chk("rst_idx",   FW'(bus.o_idx),   FW'(0));
    chk("rst_busy",  FW'(bus.o_busy),  FW'(0));
    chk("rst_mod",   dut_mod,  FW'(0));
    chk("rst_slot",  dut_slot, FW'(0));
    rst_n = 1'b1;
    tick();

    // Basic run over entries 0..3; out-of-range stage row must be ignored.
    for (int n = 0; n < 4; n++) begin
      cfg_write(n, 0, 0, 16'(n));
      cfg_write(n, 1, 8, 16'hF000 | 16'(n));
    end
    cfg_write(0, 0, 15, 16'hFFFF);
    start_run(0, 4, 1'b1);
    chk("lat_e0_valid", FW'(bus.o_valid), FW'(0));
    chk("lat_e0_busy",  FW'(bus.o_busy),  FW'(1));
    tick();
    chk("lat_e1_valid", FW'(bus.o_valid), FW'(1));
    chk("lat_e1_idx",   FW'(bus.o_idx),   FW'(0));
    wait_idle(1'b0);
    chk("end_valid", FW'(bus.o_valid), FW'(0));
    chk("end_last",  FW'(bus.o_last),  FW'(0));
    chk("end_mod_hold",  dut_mod,  last_exp.mods);
    chk("end_slot_hold", dut_slot, last_exp.slots);

    // Wrap past the top of the storage.
    cfg_write(14, 0, 3, 16'h1414);
    cfg_write(15, 1, 5, 16'h1515);
    start_run(14, 4, 1'b1);
    wait_idle(1'b0);

    // Three-cycle stall while entry 1 is presented.
    start_run(0, 4, 1'b1);
    tick(); tick();
    bus.i_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_hold_idx", FW'(bus.o_idx), FW'(1));
    end
    bus.i_stall = 1'b0;
    tick();
    chk("stall_next_idx", FW'(bus.o_idx), FW'(2));
    wait_idle(1'b0);

    // Write entry 2 on the edge that loads it: the load sees the old contents.
    start_run(0, 4, 1'b1);
    tick(); tick();
    cfg_write(2, 0, 0, 16'hAAAA);
    chk("coll_old_value", FW'(bus.o_module_select[0]), FW'(16'h0002));
    wait_idle(1'b0);
    start_run(2, 1, 1'b1);
    tick();
    chk("coll_new_value", FW'(bus.o_module_select[0]), FW'(16'hAAAA));
    wait_idle(1'b0);

    // Zero-length start is ignored.
    start_run(3, 0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk("len0_busy",  FW'(bus.o_busy),  FW'(0));
      chk("len0_valid", FW'(bus.o_valid), FW'(0));
      tick();
    end

    // Start during a run is ignored and not queued.
    start_run(4, 3, 1'b1);
    tick();
    bus.i_base = AW'(9); bus.i_len = (AW+1)'(5); bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    wait_idle(1'b0);
    tick(); tick();
    chk("nostart_queue_busy", FW'(bus.o_busy), FW'(0));

    // Randomized writes, runs and stalls; first run covers the full depth.
    for (int it = 0; it < 20; it++) begin
      int nw = $urandom_range(1, 4);
      for (int w = 0; w < nw; w++)
        cfg_write($urandom_range(0, CFG_DEPTH-1), $urandom_range(0, 1),
                  $urandom_range(0, 15), 16'($urandom));
      start_run($urandom_range(0, CFG_DEPTH-1), (it == 0) ? CFG_DEPTH : $urandom_range(1, CFG_DEPTH), 1'b1);
      wait_idle(1'b1);
    end

`ifdef BENES_CFG_LOOP_EN
    // Looping run 5,6,5,6,... then abort holds the selects.
    chk_en = 1'b0;
    cfg_write(5, 0, 1, 16'h5555);
    cfg_write(6, 0, 1, 16'h6666);
    bus.i_loop = 1'b1;
    start_run(5, 2, 1'b0);
    bus.i_loop = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("loop_valid", FW'(bus.o_valid), FW'(1));
      chk("loop_idx",   FW'(bus.o_idx),   FW'(5 + (k % 2)));
      chk("loop_last",  FW'(bus.o_last),  FW'(k % 2));
    end
    bus.i_abort = 1'b1;
    tick();
    bus.i_abort = 1'b0;
    chk("abort_valid", FW'(bus.o_valid), FW'(0));
    chk("abort_busy",  FW'(bus.o_busy),  FW'(0));
    chk("abort_hold",  dut_mod, flat(6, 0));
    chk_en = 1'b1;
`endif

    // Reset mid-run aborts immediately and clears the storage.
    start_run(0, 8, 1'b1);
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_valid", FW'(bus.o_valid), FW'(0));
    chk("midrst_last",  FW'(bus.o_last),  FW'(0));
    chk("midrst_idx",   FW'(bus.o_idx),   FW'(0));
    chk("midrst_busy",  FW'(bus.o_busy),  FW'(0));
    chk("midrst_mod",   dut_mod,  FW'(0));
    chk("midrst_slot",  dut_slot, FW'(0));
    rst_n = 1'b1;
    q.delete();
    model_clear();
    tick();
    start_run(0, 3, 1'b1);
    wait_idle(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
